// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Used by imem_loader and byte_to_word_packer.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTE_IDX_W        = 2;

endpackage

// File: rtl/byte_to_word_packer.sv
// Gathers four bytes into one little-endian 32-bit word.
// Reused by the loader for the length field, data words and checksum.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [23:0]           asm_p0;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_idx <= '0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + BYTE_IDX_W'(1);
        end
    end

    // Shift right so the first byte lands in the low lane once the fourth arrives.
    always_ff @(posedge clk) begin
        if (byte_en) begin
            asm_p0 <= {byte_in, asm_p0[23:8]};
        end
    end

    assign word_valid = byte_en && (byte_idx == BYTE_IDX_W'(3));
    assign word       = {byte_in, asm_p0};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream into instruction words, writes imem, then releases the core.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter int         MAX_WORDS  = 1024,
    parameter int         BASE_ADDR  = 0,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_run,
    output logic                  load_busy,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    state_t              state;
    logic                accept;
    logic                byte_en;
    logic                pack_clr;
    logic                word_valid;
    logic [31:0]         word;
    logic [ADDR_WIDTH:0] len_reg;
    logic [ADDR_WIDTH:0] words_next;

    assign accept     = rx_valid && rx_ready;
    assign byte_en    = accept && (state == LEN || state == DATA || state == CSUM);
    assign pack_clr   = (state == IDLE);
    assign words_next = words_loaded + (ADDR_WIDTH + 1)'(1);

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pack_clr),
        .byte_en    (byte_en),
        .byte_in    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Length is range-checked before DATA, so it always fits in ADDR_WIDTH+1 bits.
    always_ff @(posedge clk) begin
        if (state == LEN && word_valid) begin
            len_reg <= word[ADDR_WIDTH:0];
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            sum <= '0;
        end else if (state == DATA && word_valid) begin
            sum <= sum + word;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rx_ready     <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_run     <= 1'b0;
            load_busy    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        state        <= LEN;
                        load_busy    <= 1'b1;
                        words_loaded <= '0;
                    end
                end
                LEN: begin
                    if (word_valid) begin
                        if (word == 32'd0) begin
                            state     <= DONE;
                            core_run  <= 1'b1;
                            load_busy <= 1'b0;
                            rx_ready  <= 1'b0;
                        end else if (word > 32'(MAX_WORDS)) begin
                            state     <= ERROR;
                            load_err  <= 1'b1;
                            load_busy <= 1'b0;
                            rx_ready  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        imem_we      <= 1'b1;
                        imem_wdata   <= word;
                        imem_addr    <= ADDR_WIDTH'(BASE_ADDR) + words_loaded[ADDR_WIDTH-1:0];
                        words_loaded <= words_next;
                        if (words_next == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state     <= DONE;
                            core_run  <= 1'b1;
                            load_busy <= 1'b0;
                            rx_ready  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (word_valid) begin
                        load_busy <= 1'b0;
                        rx_ready  <= 1'b0;
                        if (word == sum) begin
                            state    <= DONE;
                            core_run <= 1'b1;
                        end else begin
                            state    <= ERROR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that writes the instruction memory.
- Accepts a byte stream from a UART-RX-style source, frames it into 32-bit little-endian instruction words, and drives the instruction memory write port.
- Holds the single-cycle core in reset until the whole image is written.
- Sits beside the core top: its write port feeds the instruction memory, and `core_run` drives the core's active-low reset.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width.
- MAX_WORDS, 1024, largest accepted image in words (must be ≤ 2**ADDR_WIDTH).
- BASE_ADDR, 0, word address of the first loaded word.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader accepts a byte; transfer happens when rx_valid & rx_ready are both high at a clk edge.
- imem_we  out  1  instruction memory write strobe (one-cycle pulse).
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  instruction word.
- core_run  out  1  0 = hold core in reset; 1 = release core.
- load_busy  out  1  frame in progress (LEN/DATA/CSUM states).
- load_err  out  1  sticky error flag.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current frame.

Behaviour:
- Reset values: all outputs 0, except rx_ready = 1. State = IDLE.
- `rst` mid-frame aborts the load: words already written stay in memory, and core_run stays 0.
- Frame format: SYNC_BYTE, then LEN (4 bytes, little-endian word count), then LEN×4 data bytes (little-endian per word), then, if the optional feature is enabled, a 4-byte checksum.
- IDLE:
  - Bytes other than SYNC_BYTE are accepted and discarded.
  - SYNC_BYTE → LEN; clear the byte counter and words_loaded.
- LEN:
  - Collect 4 bytes into len_reg (byte 0 = bits 7:0).
  - On the 4th byte: len = 0 → DONE; len > MAX_WORDS → ERROR; otherwise → DATA.
- DATA:
  - Shift bytes into a 32-bit assembly register; byte k lands in bits 8k+7:8k.
  - On the 4th byte of a word, the next cycle (latency 1) drives:
    - imem_we = 1
    - imem_wdata = assembled word
    - imem_addr = BASE_ADDR + words_loaded (wraps modulo 2**ADDR_WIDTH)
  - words_loaded increments in that same cycle.
  - When words_loaded reaches len → DONE, or CSUM if the feature is enabled.
- rx_ready = 1 in IDLE/LEN/DATA/CSUM and 0 in DONE/ERROR. Back-to-back bytes are accepted every cycle with no bubbles.
- A rx_valid = 0 gap leaves all state unchanged; there is no timeout.
- DONE: core_run = 1 and load_busy = 0. Terminal until rst.
- ERROR: load_err = 1 and core_run = 0. Terminal until rst.
- imem_we is never asserted outside the cycle after a completed word.
- At most MAX_WORDS writes per frame.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 32-bit modulo-2^32 sum of all data words is kept.
  - After the last word, CSUM collects 4 little-endian bytes.
  - Match → DONE. Mismatch → ERROR, with core_run held at 0.
- Undefined: no CSUM state; last word → DONE directly; no sum register is synthesized.

Decomposition:
- Shared package `imem_loader_pkg`:
  - state enum: IDLE, LEN, DATA, CSUM, DONE, ERROR
  - SYNC_BYTE default
  - byte-index width (2 bits)
- One natural sub-module, `byte_to_word_packer`:
  - 2-bit byte counter plus 32-bit shift/assembly register.
  - Outputs word_valid and word.
  - Reused for LEN, DATA and CSUM collection.

Test Plan:
- Garbage then frame: bytes 00, FF, A5, LEN 02 00 00 00, data 13 00 00 00, 93 00 10 00 (checksum 0x001000A6 when enabled) → writes:
  - addr 0 = 0x00000013
  - addr 1 = 0x00100093
  - then words_loaded = 2, core_run = 1, rx_ready = 0.
- Zero length: A5 00 00 00 00 → DONE with no imem_we pulse; core_run = 1 one cycle after the last LEN byte.
- Oversize: LEN = MAX_WORDS+1 → load_err = 1, core_run = 0, no writes, rx_ready = 0.
- Throttled source: one-word frame with rx_valid toggling every other cycle → same single write as the back-to-back case; imem_we is exactly one cycle wide.
- Reset mid-DATA: rst after 5 of 8 data bytes → outputs return to reset values; a fresh complete frame then loads correctly from BASE_ADDR.
- IMEM_LOADER_CHECKSUM_EN: correct sum → DONE; corrupted checksum byte → load_err = 1, core_run = 0, and the data words are still written.
